// File: rtl/ahb_subordinate_sram.sv
// AHB subordinate over a DEPTH x DATA_WDT register file; define AHB_SUB_RETRY_EN for periodic two-cycle RETRY.
// Data phase ends after WAIT_STATES hready-low cycles; ERROR/RETRY are two-cycle responses.
module ahb_subordinate_sram #(
  parameter int DATA_WDT     = 32,
  parameter int DEPTH        = 64,
  parameter int WAIT_STATES  = 0,
  parameter int RETRY_PERIOD = 4
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);

  localparam int NB   = DATA_WDT / 8;
  localparam int OFFW = $clog2(NB);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * NB);

  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} t_htrans;
  typedef enum logic [1:0] {HR_OKAY = 2'b00, HR_ERROR = 2'b01, HR_RETRY = 2'b10, HR_SPLIT = 2'b11} t_hresp;
`ifdef AHB_SUB_RETRY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2, ST_RTY1, ST_RTY2} t_state;
  localparam int RCW = $clog2(RETRY_PERIOD + 1);
  logic [RCW-1:0] rcnt_q, rcnt_d;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} t_state;
  localparam int unused_retry_period = RETRY_PERIOD;
`endif

  t_state              state_q, state_d;
  logic                hready_q, hready_d;
  logic [1:0]          hresp_q, hresp_d;
  logic [DATA_WDT-1:0] hrdata_q, hrdata_d;
  logic [AW-1:0]       word_q, word_d;
  logic                write_q, write_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [DATA_WDT-1:0] mem_q [DEPTH];
  logic [DATA_WDT-1:0] mem_d [DEPTH];

  logic [31:0]         size_bytes, lane_off;
  logic [AW-1:0]       acc_word;
  logic [NB-1:0]       acc_strb;
  logic                acc_err, addr_vld, commit;
  logic [DATA_WDT-1:0] wr_word;
  logic                unused_ok;

  assign unused_ok = ^i_hburst;
  assign o_hready  = hready_q;
  assign o_hresp   = hresp_q;
  assign o_hrdata  = hrdata_q;

  always_comb begin
    size_bytes = 32'd1 << i_hsize;
    lane_off   = i_haddr & 32'(NB - 1);
    acc_word   = i_haddr[OFFW +: AW];
    for (int b = 0; b < NB; b++) begin
      acc_strb[b]       = (32'(b) >= lane_off) && (32'(b) < lane_off + size_bytes);
      wr_word[8*b +: 8] = strb_q[b] ? i_hwdata[8*b +: 8] : mem_q[word_q][8*b +: 8];
    end
    acc_err  = (i_haddr >= MEM_BYTES) || (size_bytes > 32'(NB)) ||
               ((i_haddr & (size_bytes - 32'd1)) != 32'd0);
    addr_vld = i_hsel && i_hready && (i_htrans == HT_NONSEQ || i_htrans == HT_SEQ);
    commit   = (state_q == ST_DATA) && write_q;

    mem_d = mem_q;
    if (commit) mem_d[word_q] = wr_word;

    state_d  = state_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    hrdata_d = hrdata_q;
    word_d   = word_q;
    write_d  = write_q;
    strb_d   = strb_q;
    wcnt_d   = wcnt_q;
`ifdef AHB_SUB_RETRY_EN
    rcnt_d   = rcnt_q;
`endif

    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 3'd0) begin
          state_d  = ST_DATA;
          hready_d = 1'b1;
          hrdata_d = mem_q[word_q];
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
      end
`ifdef AHB_SUB_RETRY_EN
      ST_RTY1: begin
        state_d  = ST_RTY2;
        hready_d = 1'b1;
      end
`endif
      default: begin
        // IDLE, DATA and the second cycle of ERROR/RETRY all take a new address phase
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = HR_OKAY;
        if (addr_vld) begin
          word_d  = acc_word;
          write_d = i_hwrite;
          strb_d  = acc_strb;
`ifdef AHB_SUB_RETRY_EN
          if (i_htrans == HT_NONSEQ && rcnt_q == RCW'(RETRY_PERIOD - 1)) begin
            rcnt_d   = '0;
            state_d  = ST_RTY1;
            hready_d = 1'b0;
            hresp_d  = HR_RETRY;
          end else begin
            if (i_htrans == HT_NONSEQ) rcnt_d = rcnt_q + 1'b1;
`endif
            if (acc_err) begin
              state_d  = ST_ERR1;
              hready_d = 1'b0;
              hresp_d  = HR_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_d  = ST_WAIT;
              hready_d = 1'b0;
              wcnt_d   = 3'(WAIT_STATES - 1);
            end else begin
              state_d  = ST_DATA;
              // a write retiring this edge to the same word must be visible to the read
              hrdata_d = (commit && word_q == acc_word) ? wr_word : mem_q[acc_word];
            end
`ifdef AHB_SUB_RETRY_EN
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HR_OKAY;
      hrdata_q <= '0;
      word_q   <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      wcnt_q   <= '0;
`ifdef AHB_SUB_RETRY_EN
      rcnt_q   <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
      word_q   <= word_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
      wcnt_q   <= wcnt_d;
`ifdef AHB_SUB_RETRY_EN
      rcnt_q   <= rcnt_d;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_sram.sv
// Drives two subordinates (zero-wait and two-wait) with directed and random AHB traffic;
// responses, wait counts and read data are compared with a byte-array reference model.
`timescale 1ns/1ps
module tb_ahb_subordinate_sram;

  localparam int WS [2] = '{0, 2};
  localparam int RP = 4;
`ifdef AHB_SUB_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif
  localparam logic [1:0] OKAY = 2'd0, ERROR = 2'd1, RETRY = 2'd2;
  localparam int LIMIT = 4000;

  typedef struct {
    bit          wr;
    bit          seq;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        hsel     [2];
  logic [31:0] haddr    [2];
  logic [1:0]  htrans   [2];
  logic        hwrite   [2];
  logic [2:0]  hsize    [2];
  logic [2:0]  hburst   [2];
  logic [31:0] hwdata   [2];
  logic        hready_o [2];
  logic [1:0]  hresp_o  [2];
  logic [31:0] hrdata_o [2];

  ahb_subordinate_sram #(.DATA_WDT(32), .DEPTH(64), .WAIT_STATES(0), .RETRY_PERIOD(RP)) u_dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[0]), .i_haddr(haddr[0]), .i_htrans(htrans[0]),
    .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hburst(hburst[0]), .i_hwdata(hwdata[0]),
    .i_hready(hready_o[0]), .o_hrdata(hrdata_o[0]), .o_hready(hready_o[0]), .o_hresp(hresp_o[0])
  );

  ahb_subordinate_sram #(.DATA_WDT(32), .DEPTH(64), .WAIT_STATES(2), .RETRY_PERIOD(RP)) u_dut1 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[1]), .i_haddr(haddr[1]), .i_htrans(htrans[1]),
    .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hburst(hburst[1]), .i_hwdata(hwdata[1]),
    .i_hready(hready_o[1]), .o_hrdata(hrdata_o[1]), .o_hready(hready_o[1]), .o_hresp(hresp_o[1])
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_rty_exp = 0;
  int          n_rty_obs = 0;
  logic [7:0]  mmem [2][256];
  int          rcnt [2];
  logic [31:0] last_rdata [2];
  xfer_t       q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic xfer_t mk(bit wr, bit seq, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata);
    xfer_t x;
    x.wr = wr; x.seq = seq; x.addr = addr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      rcnt[k] = 0;
      for (int a = 0; a < 256; a++) mmem[k][a] = 8'h00;
    end
  endfunction

  // Sequential interpretation of the bus: each accepted transfer acts in acceptance order.
  function automatic void model_accept(input int k, input xfer_t x, output logic [1:0] er, output logic [31:0] ed);
    int nb, a, base;
    nb = 1 << x.size;
    er = OKAY;
    ed = '0;
    if (!x.seq) begin
      rcnt[k]++;
      if (RETRY_ON && rcnt[k] == RP) begin
        rcnt[k] = 0;
        er = RETRY;
        n_rty_exp++;
        return;
      end
    end
    if (x.addr >= 32'd256 || nb > 4 || (int'(x.addr) % nb) != 0) begin
      er = ERROR;
      return;
    end
    a = int'(x.addr);
    if (x.wr)
      for (int i = 0; i < nb; i++) mmem[k][a+i] = x.wdata[8*((a+i)%4) +: 8];
    base = a - (a % 4);
    ed = {mmem[k][base+3], mmem[k][base+2], mmem[k][base+1], mmem[k][base]};
  endfunction

  task automatic drive_addr(input int k, input bit vld, input xfer_t x);
    hsel[k]   = vld;
    htrans[k] = vld ? (x.seq ? 2'b11 : 2'b10) : 2'b00;
    haddr[k]  = vld ? x.addr : 32'd0;
    hwrite[k] = vld & x.wr;
    hsize[k]  = vld ? x.size : 3'd0;
    hburst[k] = 3'd0;
  endtask

  // Pipelined manager: runs the queue to completion, called #1 after a rising edge.
  task automatic run_seq(input int k);
    xfer_t       ap, dp;
    bit          ap_v, dp_v, cancel, acc;
    int          guard, ws;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    ap_v = 0; dp_v = 0; cancel = 0; guard = 0; ws = 0;
    exp_resp = OKAY; exp_rdata = '0;
    ap = mk(0, 0, 0, 0, 0);
    dp = ap;
    while ((q.size() != 0 || ap_v || dp_v) && guard < LIMIT) begin
      guard++;
      if (!ap_v && !cancel && q.size() != 0) begin
        ap = q.pop_front();
        ap_v = 1;
      end
      drive_addr(k, ap_v && !cancel, ap);
      hwdata[k] = dp_v ? dp.wdata : 32'd0;
      @(negedge clk);
      if (!hready_o[k]) begin
        if (dp_v) ws++;
        if (dp_v && hresp_o[k] != OKAY) begin
          cancel = 1;
          drive_addr(k, 0, ap);
        end
      end else begin
        acc = ap_v && !cancel;
        if (dp_v) begin
          chk($sformatf("dut%0d resp @%0h", k, dp.addr), {30'd0, hresp_o[k]}, {30'd0, exp_resp});
          chk($sformatf("dut%0d wait @%0h", k, dp.addr), 32'(ws), 32'((exp_resp == OKAY) ? WS[k] : 1));
          if (hresp_o[k] == RETRY) n_rty_obs++;
          if (!dp.wr && exp_resp == OKAY) begin
            chk($sformatf("dut%0d rdata @%0h", k, dp.addr), hrdata_o[k], exp_rdata);
            last_rdata[k] = hrdata_o[k];
          end
          if (exp_resp == RETRY) begin
            if (ap_v && !acc) begin
              q.push_front(ap);
              ap_v = 0;
            end
            dp.seq = 0;
            q.push_front(dp);
          end
          dp_v = 0;
        end
        if (acc) begin
          dp = ap;
          dp_v = 1;
          ap_v = 0;
          ws = 0;
          model_accept(k, dp, exp_resp, exp_rdata);
        end
        cancel = 0;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("dut%0d seq_done", k), 32'(q.size() == 0 && !ap_v && !dp_v), 32'd1);
    drive_addr(k, 0, ap);
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int sel;
    sel     = int'($urandom_range(99));
    x.wr    = 1'($urandom_range(1));
    x.seq   = 1'b0;
    x.wdata = $urandom();
    x.size  = 3'($urandom_range(2));
    x.addr  = ($urandom_range(1) != 0) ? 32'($urandom_range(31)) : 32'(224 + $urandom_range(31));
    x.addr  = x.addr & ~((32'd1 << x.size) - 32'd1);
    if (sel < 10) begin
      x.size = 3'($urandom_range(2, 1));
      x.addr = x.addr | 32'd1;
    end else if (sel < 16) begin
      x.size = 3'd3;
      x.addr = x.addr & ~32'd7;
    end else if (sel < 24) begin
      x.size = 3'd2;
      x.addr = 32'd256 + 32'($urandom_range(255)) * 32'd4;
    end
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_addr(k, 0, mk(0, 0, 0, 0, 0));
      hwdata[k] = 32'd0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("idle dut%0d hready", k), {31'd0, hready_o[k]}, 32'd1);
        chk($sformatf("idle dut%0d hresp", k), {30'd0, hresp_o[k]}, 32'd0);
        chk($sformatf("idle dut%0d hrdata", k), hrdata_o[k], 32'd0);
      end
    end
    @(posedge clk);
    #1;

    // INCR4 write then INCR4 read, zero-wait
    for (int i = 0; i < 4; i++) q.push_back(mk(1, i != 0, 32'(4 * i), 3'd2, 32'(i)));
    run_seq(0);
    last_rdata[0] = 32'hDEAD0000;
    for (int i = 0; i < 4; i++) q.push_back(mk(0, i != 0, 32'(4 * i), 3'd2, 32'd0));
    run_seq(0);
    chk("incr4 last beat", last_rdata[0], 32'd3);

    // two wait states
    last_rdata[1] = 32'hDEAD0000;
    q.push_back(mk(1, 0, 32'h10, 3'd2, 32'hA5A5A5A5));
    q.push_back(mk(0, 0, 32'h10, 3'd2, 32'd0));
    run_seq(1);
    chk("wait-state readback", last_rdata[1], 32'hA5A5A5A5);

    // byte lane merge, pipelined behind the full-word write
    last_rdata[0] = 32'hDEAD0000;
    q.push_back(mk(1, 0, 32'h20, 3'd2, 32'h11223344));
    q.push_back(mk(1, 0, 32'h21, 3'd0, 32'hABCDEE12));
    q.push_back(mk(0, 0, 32'h20, 3'd2, 32'd0));
    run_seq(0);
    chk("byte merge", last_rdata[0], 32'h1122EE44);

    // out of range and misaligned, memory unchanged
    last_rdata[0] = 32'hDEAD0000;
    q.push_back(mk(0, 0, 32'h100, 3'd2, 32'd0));
    q.push_back(mk(1, 0, 32'h1, 3'd1, 32'hFFFFFFFF));
    q.push_back(mk(0, 0, 32'h0, 3'd2, 32'd0));
    run_seq(0);
    chk("error no side effect", last_rdata[0], 32'd0);

    // write then immediate read of same word
    last_rdata[0] = 32'hDEAD0000;
    q.push_back(mk(1, 0, 32'h4, 3'd2, 32'h55));
    q.push_back(mk(0, 0, 32'h4, 3'd2, 32'd0));
    run_seq(0);
    chk("write bypass", last_rdata[0], 32'h55);

    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 10; i++) q.push_back(rand_xfer());
        run_seq(k);
      end

    chk("retry count", 32'(n_rty_obs), 32'(n_rty_exp));

    // reset while a write sits in its wait states
    drive_addr(1, 1, mk(1, 0, 32'h40, 3'd2, 32'h0));
    @(posedge clk);
    #1;
    drive_addr(1, 0, mk(0, 0, 0, 0, 0));
    hwdata[1] = 32'hDEADBEEF;
    chk("mid-phase hready low", {31'd0, hready_o[1]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset hready", {31'd0, hready_o[1]}, 32'd1);
    chk("reset hresp", {30'd0, hresp_o[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    last_rdata[1] = 32'hDEAD0000;
    q.push_back(mk(0, 0, 32'h40, 3'd2, 32'd0));
    run_seq(1);
    chk("write discarded by reset", last_rdata[1], 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
